// File: rtl/jump_resolve_unit.sv
// Resolves jump opcodes against the flag register (with same-cycle ALU bypass) and redirects fetch.
// Latency: jump accepted in cycle t drives pc_src/branch_target at t+1; flush high for FLUSH_SLOTS cycles.
// Backpressure: stall freezes every register; jops and flag writes are ignored while stalled or flushing.
`ifndef JUMP_BITS
`define JUMP_BITS   4
`define JMP_OP_NOP  4'd0
`define JMP_OP_J    4'd1
`define JMP_OP_JR   4'd2
`define JMP_OP_JEQ  4'd3
`define JMP_OP_JNE  4'd4
`define JMP_OP_JZ   4'd5
`define JMP_OP_JNZ  4'd6
`define JMP_OP_JL   4'd7
`define JMP_OP_JLE  4'd8
`define JMP_OP_JG   4'd9
`define JMP_OP_JGE  4'd10
`define JMP_OP_JO   4'd11
`endif

module jump_resolve_unit #(
    parameter int ADDR_WIDTH  = 16,
    parameter int FLUSH_SLOTS = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [`JUMP_BITS-1:0]   jop,
    input  logic [ADDR_WIDTH-1:0]   imm_target,
    input  logic [ADDR_WIDTH-1:0]   reg_target,
    input  logic                    flag_we,
    input  logic                    alu_z,
    input  logic                    alu_lt,
    input  logic                    alu_gt,
    input  logic                    alu_ov,
    output logic                    pc_src,
    output logic [ADDR_WIDTH-1:0]   branch_target,
    output logic                    flush,
    output logic [3:0]              flags,
    output logic [CNT_WIDTH-1:0]    taken_count
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t     state;
    logic [2:0] slot_cnt;
    logic [3:0] alu_flags;
    logic [3:0] eff_flags;
    logic       cond;

    assign alu_flags = {alu_ov, alu_gt, alu_lt, alu_z};

    // A CMP in the same cycle as the jump must win over the stale register.
    always_comb begin
        eff_flags = flag_we ? alu_flags : flags;
        cond      = 1'b0;
        case (jop)
            `JMP_OP_J,
            `JMP_OP_JR:  cond = 1'b1;
            `JMP_OP_JEQ,
            `JMP_OP_JZ:  cond = eff_flags[0];
            `JMP_OP_JNE,
            `JMP_OP_JNZ: cond = !eff_flags[0];
            `JMP_OP_JL:  cond = eff_flags[1];
            `JMP_OP_JLE: cond = eff_flags[1] | eff_flags[0];
            `JMP_OP_JG:  cond = eff_flags[2];
            `JMP_OP_JGE: cond = eff_flags[2] | eff_flags[0];
            `JMP_OP_JO:  cond = eff_flags[3];
            default:     cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            slot_cnt      <= '0;
            flags         <= '0;
            pc_src        <= 1'b0;
            branch_target <= '0;
            flush         <= 1'b0;
            taken_count   <= '0;
        end else if (!stall) begin
            pc_src <= 1'b0;
            case (state)
                IDLE: begin
                    if (flag_we)
                        flags <= alu_flags;
                    if (cond) begin
                        pc_src        <= 1'b1;
                        branch_target <= (jop == `JMP_OP_JR) ? reg_target : imm_target;
                        taken_count   <= taken_count + CNT_WIDTH'(1);
                        slot_cnt      <= 3'(FLUSH_SLOTS);
                        flush         <= 1'b1;
                        state         <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Wrong-path jops and flag writes are dropped here.
                    slot_cnt <= slot_cnt - 3'd1;
                    if (slot_cnt == 3'd1) begin
                        flush <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jump_resolve_unit.sv
// Scoreboard bench for jump_resolve_unit: a cycle model pushes expected outputs, sampled 1ns after each edge.
`ifndef JUMP_BITS
`define JUMP_BITS   4
`define JMP_OP_NOP  4'd0
`define JMP_OP_J    4'd1
`define JMP_OP_JR   4'd2
`define JMP_OP_JEQ  4'd3
`define JMP_OP_JNE  4'd4
`define JMP_OP_JZ   4'd5
`define JMP_OP_JNZ  4'd6
`define JMP_OP_JL   4'd7
`define JMP_OP_JLE  4'd8
`define JMP_OP_JG   4'd9
`define JMP_OP_JGE  4'd10
`define JMP_OP_JO   4'd11
`endif

module tb_jump_resolve_unit;
    localparam int AW = 16;
    localparam int FS = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, stall, flag_we, alu_z, alu_lt, alu_gt, alu_ov;
    logic [3:0]    jop;
    logic [AW-1:0] imm_target, reg_target;
    logic          pc_src, flush;
    logic [AW-1:0] branch_target;
    logic [3:0]    flags;
    logic [CW-1:0] taken_count;

    jump_resolve_unit #(.ADDR_WIDTH(AW), .FLUSH_SLOTS(FS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .jop(jop),
        .imm_target(imm_target), .reg_target(reg_target), .flag_we(flag_we),
        .alu_z(alu_z), .alu_lt(alu_lt), .alu_gt(alu_gt), .alu_ov(alu_ov),
        .pc_src(pc_src), .branch_target(branch_target), .flush(flush),
        .flags(flags), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          pc;
        logic [AW-1:0] tgt;
        logic          fl;
        logic [3:0]    flg;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state
    logic          m_pc;
    logic [AW-1:0] m_tgt;
    logic [3:0]    m_flags;
    int            m_left;
    logic [CW-1:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // flag vector is {ov, gt, lt, z}
    function automatic logic m_taken(input logic [3:0] j, input logic [3:0] f);
        logic z, lt, gt, ov;
        {ov, gt, lt, z} = f;
        if (j == `JMP_OP_J || j == `JMP_OP_JR)    return 1'b1;
        if (j == `JMP_OP_JEQ || j == `JMP_OP_JZ)  return z;
        if (j == `JMP_OP_JNE || j == `JMP_OP_JNZ) return ~z;
        if (j == `JMP_OP_JL)  return lt;
        if (j == `JMP_OP_JLE) return lt | z;
        if (j == `JMP_OP_JG)  return gt;
        if (j == `JMP_OP_JGE) return gt | z;
        if (j == `JMP_OP_JO)  return ov;
        return 1'b0;
    endfunction

    task automatic step(input logic rst, input logic stl, input logic [3:0] j,
                        input logic [AW-1:0] imm, input logic [AW-1:0] rt,
                        input logic fwe, input logic [3:0] alu);
        exp_t e, got;
        logic [3:0] eff;
        @(negedge clk);
        reset = rst; stall = stl; jop = j; imm_target = imm; reg_target = rt;
        flag_we = fwe; {alu_ov, alu_gt, alu_lt, alu_z} = alu;
        if (rst) begin
            m_pc = 0; m_tgt = '0; m_flags = '0; m_left = 0; m_cnt = '0;
        end else if (!stl) begin
            m_pc = 1'b0;
            if (m_left > 0) begin
                m_left--;
            end else begin
                eff = fwe ? alu : m_flags;
                if (fwe) m_flags = alu;
                if (m_taken(j, eff)) begin
                    m_pc   = 1'b1;
                    m_tgt  = (j == `JMP_OP_JR) ? rt : imm;
                    m_left = FS;
                    m_cnt  = m_cnt + 1'b1;
                end
            end
        end
        e = '{pc: m_pc, tgt: m_tgt, fl: (m_left > 0), flg: m_flags, cnt: m_cnt};
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("pc_src",        {31'd0, pc_src},        {31'd0, got.pc});
        chk("branch_target", {16'd0, branch_target}, {16'd0, got.tgt});
        chk("flush",         {31'd0, flush},         {31'd0, got.fl});
        chk("flags",         {28'd0, flags},         {28'd0, got.flg});
        chk("taken_count",   {28'd0, taken_count},   {28'd0, got.cnt});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, `JMP_OP_NOP, 16'h0, 16'h0, 0, 4'h0);
    endtask

    initial begin
        reset = 1; stall = 0; jop = '0; imm_target = '0; reg_target = '0;
        flag_we = 0; {alu_ov, alu_gt, alu_lt, alu_z} = 4'h0;
        m_pc = 0; m_tgt = '0; m_flags = '0; m_left = 0; m_cnt = '0;

        // Reset state, with stall asserted to show reset wins
        step(1, 1, `JMP_OP_J, 16'hFFFF, 16'hFFFF, 1, 4'hF);
        step(1, 0, `JMP_OP_NOP, 16'h0, 16'h0, 0, 4'h0);
        idle(1);

        // Flags set, then JEQ
        step(0, 0, `JMP_OP_NOP, 16'h0, 16'h0, 1, 4'b0001);
        step(0, 0, `JMP_OP_JEQ, 16'h0040, 16'h0, 0, 4'h0);
        chk("jeq_redirect", {31'd0, pc_src}, 32'd1);
        idle(3);

        // Bypass: JL with same-cycle lt, then JGE with gt=z=0
        step(0, 0, `JMP_OP_NOP, 16'h0, 16'h0, 1, 4'b0000);
        step(0, 0, `JMP_OP_JL, 16'h0080, 16'h0, 1, 4'b0010);
        chk("bypass_jl", {31'd0, pc_src}, 32'd1);
        idle(3);
        step(0, 0, `JMP_OP_JGE, 16'h0090, 16'h0, 1, 4'b0010);
        chk("bypass_jge", {31'd0, pc_src}, 32'd0);
        idle(1);

        // JR
        step(0, 0, `JMP_OP_JR, 16'h0010, 16'h1234, 0, 4'h0);
        chk("jr_target", {16'd0, branch_target}, 32'h1234);
        idle(3);

        // Wrong-path jops/flag writes during flush
        step(0, 0, `JMP_OP_J, 16'h0200, 16'h0, 0, 4'h0);
        step(0, 0, `JMP_OP_J, 16'h0300, 16'h0, 1, 4'b1000);
        step(0, 0, `JMP_OP_J, 16'h0300, 16'h0, 1, 4'b1000);
        chk("wrong_path_no_redirect", {31'd0, pc_src}, 32'd0);
        idle(2);

        // Stall right after a taken jump
        step(0, 0, `JMP_OP_J, 16'h0400, 16'h0, 0, 4'h0);
        for (int i = 0; i < 3; i++) step(0, 1, `JMP_OP_J, 16'h0500, 16'h0, 1, 4'hF);
        idle(4);

        // Reset during flush cycle 1
        step(0, 0, `JMP_OP_NOP, 16'h0, 16'h0, 1, 4'b0101);
        step(0, 0, `JMP_OP_J, 16'h0600, 16'h0, 0, 4'h0);
        step(1, 0, `JMP_OP_J, 16'h0700, 16'h0, 1, 4'hF);
        idle(2);

        // Exhaustive condition sweep over registered flags
        for (int f = 0; f < 16; f++) begin
            for (int j = 0; j < 16; j++) begin
                step(0, 0, `JMP_OP_NOP, 16'h0, 16'h0, 1, 4'(f));
                step(0, 0, 4'(j), AW'(16'h1000 + j * 16 + f), AW'(16'h8000 + f), 0, 4'h0);
                idle(FS);
            end
        end

        // Bypass sweep: flags written together with the jump
        for (int f = 0; f < 16; f++) begin
            for (int j = 0; j < 16; j++) begin
                step(0, 0, 4'(j), AW'(16'h2000 + j), AW'(16'h9000 + f), 1, 4'(f));
                idle(FS);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
